// File: rtl/axi_slv_ctrl_pkg.sv
// Shared types, AXI encodings and the beat address helper for the AXI slave SRAM controller.
package axi_slv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_REQ,
    RD_DATA
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Burst attributes captured at the address handshake.
  typedef struct packed {
    logic [3:0] id;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } hdr_t;

  // Callers truncate the result back to their own address width.
  function automatic logic [63:0] beat_next_addr(input logic [63:0] addr,
                                                 input logic [2:0]  size,
                                                 input logic [1:0]  burst);
    if (burst == BURST_INCR) begin
      return addr + (64'd1 << size);
    end
    return addr;
  endfunction

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-requester round-robin arbiter; grant is combinational, pointer moves on accept.
// Pointer 0 favours requester 0 (write) and is the reset state.
module axi_rr_arb2 (
  input  logic       aclk,
  input  logic       areset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr_q;

  assign grant[0] = req[0] && (!req[1] || !ptr_q);
  assign grant[1] = req[1] && (!req[0] ||  ptr_q);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ptr_q <= 1'b0;
    end else if (accept) begin
      // Hand priority to the side that did not just win.
      ptr_q <= grant[0];
    end
  end

endmodule

// File: rtl/axi_slv_mem_ctrl.sv
// AXI slave sharing one single-port SRAM between write and read bursts, one burst in flight.
// AW->wready next cycle, last W->bvalid next cycle, AR->rvalid two cycles; B/R held until ready.
module axi_slv_mem_ctrl
  import axi_slv_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                         aclk,
  input  logic                         areset,

  input  logic [3:0]                   awid,
  input  logic [ADDR_WIDTH-1:0]        awaddr,
  input  logic [7:0]                   awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
  input  logic                         awvalid,
  output logic                         awready,

  input  logic [3:0]                   wid,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic                         wlast,
  input  logic                         wvalid,
  output logic                         wready,

  output logic [3:0]                   bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,

  input  logic [3:0]                   arid,
  input  logic [ADDR_WIDTH-1:0]        araddr,
  input  logic [7:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  input  logic                         arvalid,
  output logic                         arready,

  output logic [3:0]                   rid,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  output logic                         rvalid,
  input  logic                         rready,

  output logic                         mem_en,
  output logic                         mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic [DATA_WIDTH/8-1:0]      mem_wstrb,
  input  logic [DATA_WIDTH-1:0]        mem_rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int MEM_AW = $clog2(MEM_DEPTH);

  state_t                state_q, state_d;
  hdr_t                  hdr_q, hdr_in;
  logic [ADDR_WIDTH-1:0] addr_q, addr_in, word_idx;
  logic [7:0]            cnt_q;
  logic                  burst_err_q, burst_err_in;
  logic                  err_q, err_next;
  logic                  rd_zero_q;
  logic [1:0]            arb_req, arb_grant;
  logic                  take_aw, take_ar;
  logic                  last_beat, oob, beat_err;
  logic                  wr_fire, rd_fire, rd_adv, beat_adv;
  logic                  unused_ok;

  // The write data ID is not used by this AXI4-style slave.
  assign unused_ok = ^wid;

  assign arb_req = (state_q == IDLE) ? {arvalid, awvalid} : 2'b00;

  axi_rr_arb2 u_arb (
    .aclk   (aclk),
    .areset (areset),
    .req    (arb_req),
    .accept (|arb_grant),
    .grant  (arb_grant)
  );

  assign take_aw = arb_grant[0];
  assign take_ar = arb_grant[1];
  assign awready = take_aw;
  assign arready = take_ar;

  assign hdr_in  = take_ar ? hdr_t'{id: arid, len: arlen, size: arsize, burst: arburst}
                           : hdr_t'{id: awid, len: awlen, size: awsize, burst: awburst};
  assign addr_in = take_ar ? araddr : awaddr;

  // Burst-wide errors are known at the handshake and poison every beat.
  assign burst_err_in = !(hdr_in.burst == BURST_FIXED || hdr_in.burst == BURST_INCR) ||
                        (hdr_in.size > 3'(OFFS));

  assign word_idx  = addr_q >> OFFS;
  assign oob       = (word_idx >= ADDR_WIDTH'(MEM_DEPTH));
  assign last_beat = (cnt_q == hdr_q.len);
  assign wr_fire   = (state_q == WR_DATA) && wvalid;
  assign rd_fire   = (state_q == RD_REQ);
  assign beat_err  = burst_err_q || oob ||
                     ((state_q == WR_DATA) && (wlast != last_beat));
  assign err_next  = err_q || ((wr_fire || rd_fire) && beat_err);
  assign rd_adv    = (state_q == RD_DATA) && rready && !last_beat;
  assign beat_adv  = (wr_fire && !last_beat) || rd_adv;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take_aw) begin
          state_d = WR_DATA;
        end else if (take_ar) begin
          state_d = RD_REQ;
        end
      end
      WR_DATA: begin
        if (wvalid && last_beat) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bready) begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rready) begin
          state_d = last_beat ? IDLE : RD_REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // SRAM strobes and address are zero whenever no access is issued.
  always_comb begin
    wready    = (state_q == WR_DATA);
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    rdata     = '0;
    if (wr_fire && !beat_err) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = word_idx[MEM_AW-1:0];
      mem_wdata = wdata;
      mem_wstrb = wstrb;
    end
    if (rd_fire && !beat_err) begin
      mem_en   = 1'b1;
      mem_addr = word_idx[MEM_AW-1:0];
    end
    if ((state_q == RD_DATA) && !rd_zero_q) begin
      rdata = mem_rdata;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      hdr_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= 8'd0;
      burst_err_q <= 1'b0;
      err_q       <= 1'b0;
      rd_zero_q   <= 1'b0;
      bvalid      <= 1'b0;
      bid         <= '0;
      bresp       <= RESP_OKAY;
      rvalid      <= 1'b0;
      rid         <= '0;
      rresp       <= RESP_OKAY;
      rlast       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_aw || take_ar) begin
        hdr_q       <= hdr_in;
        addr_q      <= addr_in;
        cnt_q       <= 8'd0;
        burst_err_q <= burst_err_in;
        err_q       <= 1'b0;
      end else begin
        err_q <= err_next;
        // The counter stops at len, so a 256-beat burst never wraps it.
        if (beat_adv) begin
          cnt_q  <= cnt_q + 8'd1;
          addr_q <= ADDR_WIDTH'(beat_next_addr(64'(addr_q), hdr_q.size, hdr_q.burst));
        end
      end
      if (rd_fire) begin
        rd_zero_q <= beat_err;
      end
      bvalid <= (state_d == WR_RESP);
      bid    <= (state_d == WR_RESP) ? hdr_q.id : 4'd0;
      bresp  <= ((state_d == WR_RESP) && err_next) ? RESP_SLVERR : RESP_OKAY;
      rvalid <= (state_d == RD_DATA);
      rid    <= (state_d == RD_DATA) ? hdr_q.id : 4'd0;
      rresp  <= ((state_d == RD_DATA) && err_next) ? RESP_SLVERR : RESP_OKAY;
      rlast  <= (state_d == RD_DATA) && last_beat;
    end
  end

endmodule
